seg_display_mux: RTL and testbench
==================================

# seg_display_mux

Time-multiplexed driver for the lab board's dual common-anode seven-segment display. It consumes the two registered hex digits produced by the keypad scanner: Sw1 is the older key, Sw2 the most recent. It alternates the shared cathode bus between the two digits at a fixed refresh rate, with optional all-off dead-time between digits to suppress ghosting. All outputs are registered and glitch-free.

## Interface
- ON_CYCLES, default 24000: Clk cycles each digit is lit (0.5 ms at 48 MHz); minimum 2.
- BLANK_CYCLES, default 480: Clk cycles of all-off dead-time after each digit; minimum 1; used only with DISP_DEADTIME_EN.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Sw1  in  4  hex value for digit 1 (left), from the keypad stage.
- Sw2  in  4  hex value for digit 2 (right), from the keypad stage.
- Seg  out  7  active-low cathodes {g,f,e,d,c,b,a}.
- An1  out  1  active-low enable, digit 1 (PNP base drive).
- An2  out  1  active-low enable, digit 2.

## Operation
- States: START, DIG1, BLANK1, DIG2, BLANK2.
- Reset (asynchronous, immediate): state START, counter 0, Seg = 7'b1111111, An1 = 1, An2 = 1.
- START lasts one cycle, then goes to DIG1.
- DIG1 and DIG2 each last exactly ON_CYCLES cycles. BLANK1 and BLANK2 each last exactly BLANK_CYCLES cycles.
- State order: DIG1 → BLANK1 → DIG2 → BLANK2 → DIG1.
- Phase counter:
  - Width is $clog2 of max(ON_CYCLES, BLANK_CYCLES).
  - Clears on every state change.
  - The phase ends on the cycle the counter equals its length − 1.
- Digit capture:
  - On the edge entering DIG1, Seg loads decode(Sw1) and An1 goes to 0.
  - On the edge entering DIG2, Seg loads decode(Sw2) and An2 goes to 0.
  - The value sampled is the Sw present at that edge.
  - Sw changes during a lit phase are ignored until that digit's next lit phase.
- Blank states: Seg = 7'b1111111, An1 = 1, An2 = 1.
- Invariant: An1 and An2 are never both 0 in any cycle.
- Decoding (active low), g..a:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110

## Timing
- First lit cycle is the first rising edge after Reset deasserts (START → DIG1).
- Frame period is 2·(ON_CYCLES + BLANK_CYCLES) with the macro, 2·ON_CYCLES without.
- Worst-case latency from an Sw2 change to display: one frame period.
- Seg and the anode change on the same edge. Seg is never driven with a new digit while the previous anode is still enabled, because either a blank phase intervenes or both transition in one edge.
- Reset asserted mid-phase: outputs go off within the same cycle; the sequence restarts at START.
- Equal Sw1/Sw2 values or repeated keys: no special handling.

## Configuration
- DISP_DEADTIME_EN defined: BLANK1/BLANK2 are present with BLANK_CYCLES dead-time.
- DISP_DEADTIME_EN undefined:
  - BLANK states are removed; DIG1 → DIG2 → DIG1 directly.
  - BLANK_CYCLES is ignored.
  - The counter only needs to count ON_CYCLES.
  - The never-both-enabled invariant still holds.

## Structure
- Package seg_pkg:
  - state typedef (enum logic [2:0]: START, DIG1, BLANK1, DIG2, BLANK2).
  - SEG_BLANK = 7'b1111111.
  - Per-digit segment constants.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit active-low decoder. It is instantiated once; its input is muxed between Sw1 and Sw2 by next state.
- Top module holds the FSM, phase counter, and output registers.

## Test plan
Use ON_CYCLES = 4, BLANK_CYCLES = 2, DISP_DEADTIME_EN defined, unless noted.
- Reset:
  - During Reset: Seg = 7F, An1 = An2 = 1.
  - First edge after release: An1 = 0, Seg = decode(Sw1).
- Sw1 = 1, Sw2 = A, steady:
  - An1 low 4 cycles with Seg = 1111001.
  - Then 2 cycles all off, Seg = 1111111.
  - Then An2 low 4 cycles with Seg = 0001000.
  - Period 12.
- Sw1 changes 3 → 8 mid-DIG1:
  - Seg holds 0110000 to the phase end.
  - Next DIG1 shows 0000000.
- Sweep Sw2 through 0–F, one value per frame: each DIG2 Seg matches the decode list.
- Reset asserted in cycle 2 of DIG2:
  - Same cycle: An2 = 1, Seg = 7F.
  - After release, restarts with DIG1.
- DISP_DEADTIME_EN undefined:
  - Period 8.
  - Anodes alternate every 4 cycles.
  - An1 and An2 are never both 0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and segment patterns for the dual-digit seven-segment driver.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

  typedef enum logic [2:0] {
    StStart  = 3'd0,
    StDig1   = 3'd1,
    StBlank1 = 3'd2,
    StDig2   = 3'd3,
    StBlank2 = 3'd4
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low seven-segment pattern decoder.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for a dual common-anode seven-segment display.
// Define DISP_DEADTIME_EN to insert BLANK_CYCLES of all-off dead-time after each digit.
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int unsigned ON_CYCLES    = 24000,
  parameter int unsigned BLANK_CYCLES = 480
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Sw1,
  input  logic [3:0] Sw2,
  output logic [6:0] Seg,
  output logic       An1,
  output logic       An2
);

`ifdef DISP_DEADTIME_EN
  localparam bit DeadTime = 1'b1;
`else
  localparam bit DeadTime = 1'b0;
`endif

  localparam int unsigned CntLen = (DeadTime && (BLANK_CYCLES > ON_CYCLES)) ? BLANK_CYCLES
                                                                            : ON_CYCLES;
  localparam int unsigned CntW   = (CntLen > 1) ? $clog2(CntLen) : 1;

  localparam logic [CntW-1:0] OnLast = CntW'(ON_CYCLES - 1);
`ifdef DISP_DEADTIME_EN
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      digit_sel;
  logic [6:0]      seg_dec;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StStart: state_d = StDig1;
`ifdef DISP_DEADTIME_EN
      StDig1:   if (cnt_q == OnLast)    state_d = StBlank1;
      StBlank1: if (cnt_q == BlankLast) state_d = StDig2;
      StDig2:   if (cnt_q == OnLast)    state_d = StBlank2;
      StBlank2: if (cnt_q == BlankLast) state_d = StDig1;
`else
      StDig1:   if (cnt_q == OnLast)    state_d = StDig2;
      StDig2:   if (cnt_q == OnLast)    state_d = StDig1;
`endif
      default:  state_d = StStart;
    endcase
  end

  // Single decoder, fed by whichever digit is about to be lit.
  assign digit_sel = (state_d == StDig2) ? Sw2 : Sw1;

  hex_to_seg7 u_hex_to_seg7 (
    .hex (digit_sel),
    .seg (seg_dec)
  );

  // Outputs only change on a state change, so Seg and anodes switch together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StStart;
      cnt_q   <= '0;
      Seg     <= SEG_BLANK;
      An1     <= 1'b1;
      An2     <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
        unique case (state_d)
          StDig1: begin
            Seg <= seg_dec;
            An1 <= 1'b0;
            An2 <= 1'b1;
          end
          StDig2: begin
            Seg <= seg_dec;
            An1 <= 1'b1;
            An2 <= 1'b0;
          end
          default: begin
            Seg <= SEG_BLANK;
            An1 <= 1'b1;
            An2 <= 1'b1;
          end
        endcase
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux with ON_CYCLES=4, BLANK_CYCLES=2.
module tb_seg_display_mux;

  localparam int ON = 4;
`ifdef DISP_DEADTIME_EN
  localparam int BL = 2;
`else
  localparam int BL = 0;
`endif
  localparam int Period = 2 * (ON + BL);

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Sw1 = 4'h0;
  logic [3:0] Sw2 = 4'h0;
  logic [6:0] Seg;
  logic       An1, An2;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] sb_q[$];

  int         m_pos = 0;
  bit         m_started = 1'b0;
  logic [3:0] m_lat1 = 4'h0;
  logic [3:0] m_lat2 = 4'h0;

  seg_display_mux #(
    .ON_CYCLES    (4),
    .BLANK_CYCLES (2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Sw1   (Sw1),
    .Sw2   (Sw2),
    .Seg   (Seg),
    .An1   (An1),
    .An2   (An2)
  );

  always #5 Clk = ~Clk;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Advance the frame model one cycle, queue its expectation, then compare after the edge.
  task automatic step();
    logic [8:0] exp;
    logic [8:0] head;
    if (!m_started) begin
      m_started = 1'b1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % Period;
    end
    if (m_pos == 0) m_lat1 = Sw1;
    if (m_pos == ON + BL) m_lat2 = Sw2;
    if (m_pos < ON) exp = {dec(m_lat1), 1'b0, 1'b1};
    else if (m_pos < ON + BL) exp = {7'h7F, 1'b1, 1'b1};
    else if (m_pos < 2 * ON + BL) exp = {dec(m_lat2), 1'b1, 1'b0};
    else exp = {7'h7F, 1'b1, 1'b1};
    sb_q.push_back(exp);
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 9'd0, 9'd1);
    end else begin
      head = sb_q.pop_front();
      check("frame", {Seg, An1, An2}, head);
    end
    check("an_excl", {8'd0, ~(~An1 & ~An2)}, 9'd1);
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 4 * Period; i++) begin
      step();
      if (m_pos == target) return;
    end
  endtask

  initial begin
    Sw1 = 4'h1;
    Sw2 = 4'hA;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_hold", {Seg, An1, An2}, {7'h7F, 1'b1, 1'b1});
    Reset = 1'b0;
    m_started = 1'b0;

    // Steady digits over two frames.
    repeat (2 * Period) step();

    // Sw1 change mid-DIG1 must not show until the next DIG1.
    Sw1 = 4'h3;
    run_to(1);
    Sw1 = 4'h8;
    repeat (Period + ON) step();

    // Sweep Sw2 through every hex value.
    for (int v = 0; v < 16; v++) begin
      Sw2 = 4'(v);
      repeat (Period) step();
    end

    // Asynchronous reset in the second cycle of DIG2.
    run_to(ON + BL + 1);
    #3;
    Reset = 1'b1;
    #1;
    check("rst_async", {Seg, An1, An2}, {7'h7F, 1'b1, 1'b1});
    @(posedge Clk);
    #1;
    check("rst_held", {Seg, An1, An2}, {7'h7F, 1'b1, 1'b1});
    Reset = 1'b0;
    m_started = 1'b0;
    Sw1 = 4'hC;
    repeat (Period + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
